// File: rtl/full_subtractor_core.sv
// Combinational 1-bit full subtractor: a - b - c, with the five gate nodes kept as
// separate observable outputs.
module full_subtractor_core (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic w1,
  output logic w2,
  output logic w3,
  output logic w4,
  output logic w5,
  output logic d,
  output logic bout
);

  // Gate nodes stay as written; they are exported for gate-level debug.
  assign w1   = a ^ b;
  assign w2   = ~a;
  assign w3   = w2 & b;
  assign w4   = w2 & c;
  assign w5   = b & c;
  assign d    = w1 ^ c;
  assign bout = w3 | w4 | w5;

endmodule

// File: rtl/full_subtractor.sv
// Full subtractor leaf cell with an optional output register bank for pipelined
// ripple-borrow chains.
module full_subtractor #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic w1,
  output logic w2,
  output logic w3,
  output logic w4,
  output logic w5,
  output logic d,
  output logic bout
);

  logic w1_d, w2_d, w3_d, w4_d, w5_d, d_d, bout_d;

  full_subtractor_core u_core (
    .a    (a),
    .b    (b),
    .c    (c),
    .w1   (w1_d),
    .w2   (w2_d),
    .w3   (w3_d),
    .w4   (w4_d),
    .w5   (w5_d),
    .d    (d_d),
    .bout (bout_d)
  );

  if (OUT_REG) begin : g_out_reg
    logic w1_q, w2_q, w3_q, w4_q, w5_q, d_q, bout_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        w1_q   <= 1'b0;
        w2_q   <= 1'b0;
        w3_q   <= 1'b0;
        w4_q   <= 1'b0;
        w5_q   <= 1'b0;
        d_q    <= 1'b0;
        bout_q <= 1'b0;
      end else begin
        w1_q   <= w1_d;
        w2_q   <= w2_d;
        w3_q   <= w3_d;
        w4_q   <= w4_d;
        w5_q   <= w5_d;
        d_q    <= d_d;
        bout_q <= bout_d;
      end
    end

    assign w1   = w1_q;
    assign w2   = w2_q;
    assign w3   = w3_q;
    assign w4   = w4_q;
    assign w5   = w5_q;
    assign d    = d_q;
    assign bout = bout_q;
  end else begin : g_out_comb
    // Clock and reset are intentionally unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign w1   = w1_d;
    assign w2   = w2_d;
    assign w3   = w3_d;
    assign w4   = w4_d;
    assign w5   = w5_d;
    assign d    = d_d;
    assign bout = bout_d;
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench for full_subtractor: registered (OUT_REG=1) and combinational
// (OUT_REG=0) builds driven from the same a/b/c.
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0;

  logic r_w1, r_w2, r_w3, r_w4, r_w5, r_d, r_bout;
  logic c_w1, c_w2, c_w3, c_w4, c_w5, c_d, c_bout;

  int compared = 0;
  int mismatched = 0;

  // Hand-derived truth tables, bit index = {a,b,c}.
  logic [7:0] t_w1, t_w2, t_w3, t_w4, t_w5, t_d, t_bout;

  always #5 clk = ~clk;

  full_subtractor #(.OUT_REG(1'b1)) u_reg (
    .clk (clk), .rst (rst), .a (a), .b (b), .c (c),
    .w1 (r_w1), .w2 (r_w2), .w3 (r_w3), .w4 (r_w4), .w5 (r_w5),
    .d (r_d), .bout (r_bout)
  );

  full_subtractor #(.OUT_REG(1'b0)) u_comb (
    .clk (clk), .rst (rst), .a (a), .b (b), .c (c),
    .w1 (c_w1), .w2 (c_w2), .w3 (c_w3), .w4 (c_w4), .w5 (c_w5),
    .d (c_d), .bout (c_bout)
  );

  function automatic logic [6:0] tab_vec(input int unsigned i);
    return {t_w1[i], t_w2[i], t_w3[i], t_w4[i], t_w5[i], t_d[i], t_bout[i]};
  endfunction

  task automatic check_reg(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {r_w1, r_w2, r_w3, r_w4, r_w5, r_d, r_bout};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed {w1..w5,d,bout}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {c_w1, c_w2, c_w3, c_w4, c_w5, c_d, c_bout};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed {w1..w5,d,bout}=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    t_w1   = 8'b0011_1100;
    t_w2   = 8'b0000_1111;
    t_w3   = 8'b0000_1100;
    t_w4   = 8'b0000_1010;
    t_w5   = 8'b1000_1000;
    t_d    = 8'b1001_0110;
    t_bout = 8'b1000_1110;

    // Reset held from time 0.
    #2;
    check_reg("reset_state", 7'b0000000);
    check_comb("comb_during_reset_000", 7'b0100000);

    @(negedge clk);
    rst = 1'b0;

    // Exhaustive sweep, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a, b, c} = 3'(i);
      #1;
      check_comb($sformatf("comb_sweep_%0d", i), tab_vec(i));
      @(posedge clk);
      #1;
      check_reg($sformatf("reg_sweep_%0d", i), tab_vec(i));
    end

    // Directed vectors with explicitly listed node values.
    @(negedge clk);
    {a, b, c} = 3'b011;
    @(posedge clk);
    #1;
    check_reg("reg_011_nodes", 7'b1111101);
    check_comb("comb_011_nodes", 7'b1111101);

    @(negedge clk);
    {a, b, c} = 3'b100;
    @(posedge clk);
    #1;
    check_reg("reg_100_nodes", 7'b1000010);
    check_comb("comb_100_nodes", 7'b1000010);

    // Async reset between edges, then reload on first edge after release.
    @(negedge clk);
    {a, b, c} = 3'b001;
    @(posedge clk);
    #1;
    check_reg("reg_001_loaded", 7'b0101011);
    #1;
    rst = 1'b1;
    #1;
    check_reg("async_reset_clears", 7'b0000000);
    check_comb("comb_ignores_rst_high", 7'b0101011);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reg("held_after_release", 7'b0000000);
    check_comb("comb_ignores_rst_low", 7'b0101011);
    @(posedge clk);
    #1;
    check_reg("reload_after_reset", 7'b0101011);

    // Mid-cycle input change must not reach registered outputs before the edge.
    @(negedge clk);
    {a, b, c} = 3'b111;
    @(posedge clk);
    #1;
    check_reg("reg_111_loaded", 7'b0000111);
    #1;
    {a, b, c} = 3'b000;
    #1;
    check_reg("latency_hold_early", 7'b0000111);
    check_comb("comb_000_immediate", 7'b0100000);
    @(negedge clk);
    check_reg("latency_hold_negedge", 7'b0000111);
    @(posedge clk);
    #1;
    check_reg("latency_update_000", 7'b0100000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
